// File: rtl/video_pkg.sv
// video_pkg: shared FSM encoding and plane-index width for the video address generator.
package video_pkg;
   localparam int PLANE_W = 2;
   typedef enum logic [1:0] {IDLE, LINE, WAIT} state_t;
endpackage

// File: rtl/video_wrap_add.sv
// video_wrap_add: (a + b) mod n, yields 0 when n is 0.
module video_wrap_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] n,
   output logic [W-1:0] y
);
   logic [W:0] s;
   assign s = {1'b0, a} + {1'b0, b};
   assign y = (n == '0) ? '0 : W'(s % {1'b0, n});
endmodule

// File: rtl/video_plane_addrgen.sv
// video_plane_addrgen: interleaved multi-plane DRAM fetch address generator.
// Define VIDEO_ADDRGEN_SCROLL_EN to compile in scroll_x/scroll_y support.
module video_plane_addrgen
   import video_pkg::*;
#(
   parameter int          AW        = 21,
   parameter int          NPLANES   = 2,
   parameter int unsigned PLANE_OFS = 21'h2000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               int_start,
   input  logic               line_start,
   input  logic               vpix,
   input  logic               video_next,
   input  logic [AW-1:0]      base_addr,
   input  logic [11:0]        stride,
   input  logic [7:0]         line_words,
   input  logic [7:0]         scroll_x,
   input  logic [8:0]         scroll_y,
   output logic [AW-1:0]      video_addr,
   output logic               addr_valid,
   output logic [PLANE_W-1:0] plane,
   output logic               line_done
);
   state_t state, state_n;
   logic [AW-1:0] row_base, row_n, addr_n, start_row;
   logic [7:0] word, word_n, lw_r, wx_n;
   logic [11:0] stride_r;
   logic [PLANE_W-1:0] plane_n;
   logic valid_n, done_n, pl_last, last;
`ifdef VIDEO_ADDRGEN_SCROLL_EN
   logic [7:0] sx_r;
   always_ff @(posedge clk)
      if (rst) sx_r <= '0;
      else if (int_start) sx_r <= scroll_x;
   video_wrap_add #(.W(8)) u_wx (.a(word_n), .b(sx_r), .n(lw_r), .y(wx_n));
   assign start_row = base_addr + AW'(scroll_y) * AW'(stride);
`else
   logic unused_scroll;
   assign unused_scroll = ^{scroll_x, scroll_y};
   assign wx_n = word_n;
   assign start_row = base_addr;
`endif
   assign pl_last = plane == PLANE_W'(NPLANES - 1);
   assign last = pl_last && word == lw_r - 8'd1;
   always_comb begin
      state_n = state;
      row_n   = row_base;
      word_n  = word;
      plane_n = plane;
      valid_n = addr_valid;
      done_n  = 1'b0;
      if (int_start) begin
         state_n = IDLE;
         row_n   = start_row;
         word_n  = '0;
         plane_n = '0;
         valid_n = 1'b0;
      end else if (line_start && vpix) begin
         // a restart mid-line abandons the current row and moves on to the next
         row_n   = state == LINE ? row_base + AW'(stride_r) : row_base;
         state_n = LINE;
         word_n  = '0;
         plane_n = '0;
         valid_n = 1'b1;
      end else if (video_next && state == LINE) begin
         if (last) begin
            state_n = WAIT;
            row_n   = row_base + AW'(stride_r);
            word_n  = '0;
            plane_n = '0;
            valid_n = 1'b0;
            done_n  = 1'b1;
         end else begin
            plane_n = pl_last ? '0 : plane + PLANE_W'(1);
            word_n  = pl_last ? word + 8'd1 : word;
         end
      end
      addr_n = row_n + AW'(plane_n) * AW'(PLANE_OFS) + AW'(wx_n);
   end
   always_ff @(posedge clk)
      if (rst) begin
         state      <= IDLE;
         row_base   <= '0;
         word       <= '0;
         plane      <= '0;
         video_addr <= '0;
         addr_valid <= 1'b0;
         line_done  <= 1'b0;
         lw_r       <= '0;
         stride_r   <= '0;
      end else begin
         state      <= state_n;
         row_base   <= row_n;
         word       <= word_n;
         plane      <= plane_n;
         video_addr <= addr_n;
         addr_valid <= valid_n;
         line_done  <= done_n;
         if (int_start) begin
            lw_r     <= line_words;
            stride_r <= stride;
         end
      end
endmodule

// File: tb/tb_video_plane_addrgen.sv
// tb_video_plane_addrgen: directed self-checking bench for video_plane_addrgen (AW 21, 2 planes).
module tb_video_plane_addrgen;
   import video_pkg::*;
   logic clk = 0, rst = 1, int_start = 0, line_start = 0, vpix = 0, video_next = 0;
   logic [20:0] base_addr = 0;
   logic [11:0] stride = 0;
   logic [7:0] line_words = 0, scroll_x = 0;
   logic [8:0] scroll_y = 0;
   logic [20:0] video_addr;
   logic addr_valid, line_done;
   logic [1:0] plane;
   int n_checks = 0, n_errs = 0;
   video_plane_addrgen dut (
      .clk(clk), .rst(rst), .int_start(int_start), .line_start(line_start), .vpix(vpix),
      .video_next(video_next), .base_addr(base_addr), .stride(stride), .line_words(line_words),
      .scroll_x(scroll_x), .scroll_y(scroll_y), .video_addr(video_addr), .addr_valid(addr_valid),
      .plane(plane), .line_done(line_done)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic frame(input logic [20:0] b, input logic [11:0] s, input logic [7:0] lw,
                        input logic [7:0] sx, input logic [8:0] sy);
      base_addr = b; stride = s; line_words = lw; scroll_x = sx; scroll_y = sy;
      int_start = 1; tick(); int_start = 0;
   endtask
   task automatic start_line();
      line_start = 1; vpix = 1; tick(); line_start = 0; vpix = 0;
   endtask
   logic [20:0] exp_basic [8] = '{21'h1000, 21'h3000, 21'h1001, 21'h3001, 21'h1002, 21'h3002, 21'h1003, 21'h3003};
   logic [7:0] sw [4];
   logic [20:0] srow;
   initial begin
      for (int i = 0; i < 3; i++) begin
         int_start = i[0]; video_next = ~i[0]; base_addr = 21'h1234; tick();
      end
      check("rst_addr", video_addr, 0);
      check("rst_valid", addr_valid, 0);
      check("rst_plane", plane, 0);
      check("rst_done", line_done, 0);
      check("rst_state", dut.state, IDLE);
      rst = 0; int_start = 0; video_next = 0;
      frame(21'h1000, 12'd32, 8'd4, 8'd0, 9'd0);
      start_line();
      video_next = 1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("basic_addr%0d", i), video_addr, exp_basic[i]);
         check($sformatf("basic_valid%0d", i), addr_valid, 1);
         check($sformatf("basic_plane%0d", i), plane, i % 2);
         check($sformatf("basic_done%0d", i), line_done, 0);
         tick();
      end
      check("end_valid", addr_valid, 0);
      check("end_done", line_done, 1);
      check("end_state", dut.state, WAIT);
      tick();
      check("wait_done_clear", line_done, 0);
      check("wait_ignore_next", addr_valid, 0);
      video_next = 0;
      line_start = 1; vpix = 0; tick(); line_start = 0;
      check("novpix_valid", addr_valid, 0);
      check("novpix_state", dut.state, WAIT);
      start_line();
      check("line2_addr", video_addr, 21'h1020);
      check("line2_valid", addr_valid, 1);
      frame(21'h0, 12'd32, 8'd4, 8'd3, 9'd2);
`ifdef VIDEO_ADDRGEN_SCROLL_EN
      sw = '{8'd3, 8'd0, 8'd1, 8'd2}; srow = 21'h40;
`else
      sw = '{8'd0, 8'd1, 8'd2, 8'd3}; srow = 21'h0;
`endif
      start_line();
      video_next = 1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("scroll_p0_%0d", i), video_addr, srow + 21'(sw[i]));
         tick();
         check($sformatf("scroll_p1_%0d", i), video_addr, srow + 21'h2000 + 21'(sw[i]));
         tick();
      end
      check("scroll_done", line_done, 1);
      video_next = 0;
      frame(21'h1FFFFF, 12'd32, 8'd4, 8'd0, 9'd0);
      start_line();
      check("wrap_w0p0", video_addr, 21'h1FFFFF);
      video_next = 1; tick();
      check("wrap_w0p1", video_addr, 21'h001FFF);
      tick();
      check("wrap_w1p0", video_addr, 21'h000000);
      check("wrap_valid", addr_valid, 1);
      base_addr = 21'h5000; stride = 12'd32; line_words = 8'd8;
      int_start = 1; line_start = 1; vpix = 1; tick();
      int_start = 0; line_start = 0; vpix = 0; video_next = 0;
      check("coll_state", dut.state, IDLE);
      check("coll_valid", addr_valid, 0);
      check("coll_row", dut.row_base, 21'h5000);
      start_line();
      check("mid_first", video_addr, 21'h5000);
      video_next = 1;
      tick(); tick(); tick();
      check("mid_third", video_addr, 21'h7001);
      line_start = 1; vpix = 1; tick(); line_start = 0; vpix = 0; video_next = 0;
      check("mid_addr", video_addr, 21'h5020);
      check("mid_plane", plane, 0);
      check("mid_valid", addr_valid, 1);
      check("mid_nodone", line_done, 0);
      tick();
      check("mid_hold", video_addr, 21'h5020);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule
